// File: rtl/vga_pkg.sv
// Shared raster constants and coordinate type for the VGA pixel pipeline.
// The 640-wide row is split as 5 * 128 so a column is {addr_hi mod 5, addr[6:0]}.
package vga_pkg;

    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int FRAME_PIXELS = H_RES * V_RES;
    localparam int ADDR_W       = 19;
    localparam int COORD_W      = 10;

    localparam int X_LO_W = 7;
    localparam int X_HI_W = ADDR_W - X_LO_W;

    // floor(q * 3277 / 2^14) equals q / 5 for every 12-bit q; the divider still fixes up the remainder.
    localparam int DIV5_RECIP = 3277;
    localparam int DIV5_SHIFT = 14;
    localparam int DIV5_PROD_W = 2 * X_HI_W;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

endpackage

// File: rtl/addr_to_cart_div5_12b.sv
// Combinational exact 12-bit unsigned divide-by-5 using a reciprocal multiply
// followed by a single-step remainder correction.
module div5_12b
    import vga_pkg::*;
(
    input  logic [X_HI_W-1:0]  i_dividend,
    output logic [COORD_W-1:0] o_quotient,
    output logic [2:0]         o_remainder
);

    logic [COORD_W-1:0] w_quotEst;
    logic [COORD_W-1:0] w_quot;
    logic [X_HI_W-1:0]  w_remWide;

    assign w_quotEst = COORD_W'((DIV5_PROD_W'(i_dividend) * DIV5_PROD_W'(DIV5_RECIP)) >> DIV5_SHIFT);

    always_comb begin
        w_quot    = w_quotEst;
        w_remWide = i_dividend - (X_HI_W'(w_quotEst) * X_HI_W'(5));
        // Guards against an under-estimated quotient so the result never depends on the reciprocal being perfect.
        if (w_remWide >= X_HI_W'(5)) begin
            w_quot    = w_quotEst + COORD_W'(1);
            w_remWide = w_remWide - X_HI_W'(5);
        end
    end

    assign o_quotient  = w_quot;
    assign o_remainder = 3'(w_remWide);

endmodule

// File: rtl/addr_to_cart.sv
// Two-stage pipeline turning a linear 640x480 frame-buffer address into (x, y),
// with a valid strobe and an out-of-frame flag travelling alongside.
module addr_to_cart
    import vga_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              addr_valid,
    input  logic [ADDR_W-1:0] curAddress,
    output logic [COORD_W-1:0] curX,
    output logic [COORD_W-1:0] curY,
    output logic              coord_valid,
    output logic              out_of_range
);

    logic [X_LO_W-1:0]  r_lo7;
    logic [X_HI_W-1:0]  r_q;
    logic               r_oor1;
    logic               r_valid1;

    coord_t             r_coord;
    logic               r_oor2;
    logic               r_valid2;

    logic [COORD_W-1:0] w_quot;
    logic [2:0]         w_rem;

    // Stage 1 splits the address at bit 7; data registers load even on idle cycles.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_lo7    <= '0;
            r_q      <= '0;
            r_oor1   <= 1'b0;
            r_valid1 <= 1'b0;
        end else begin
            r_lo7    <= curAddress[X_LO_W-1:0];
            r_q      <= curAddress[ADDR_W-1:X_LO_W];
            r_oor1   <= (curAddress >= ADDR_W'(FRAME_PIXELS));
            r_valid1 <= addr_valid;
        end
    end

    div5_12b u_div5 (
        .i_dividend  (r_q),
        .o_quotient  (w_quot),
        .o_remainder (w_rem)
    );

    // Stage 2: remainder*128 + lo7 is a plain concatenation since lo7 < 128.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_coord  <= '0;
            r_oor2   <= 1'b0;
            r_valid2 <= 1'b0;
        end else begin
            r_coord.x <= {w_rem, r_lo7};
            r_coord.y <= w_quot;
            r_oor2    <= r_oor1;
            r_valid2  <= r_valid1;
        end
    end

    assign curX         = r_coord.x;
    assign curY         = r_coord.y;
    assign coord_valid  = r_valid2;
    assign out_of_range = r_oor2;

endmodule

// File: tb/tb_addr_to_cart.sv
// Scoreboard bench for addr_to_cart: random and boundary addresses against a
// div/mod-640 reference model, plus reset flush and idle-drain behaviour.
module tb_addr_to_cart;

    logic        clock;
    logic        resetn;
    logic        addr_valid;
    logic [18:0] curAddress;
    logic [9:0]  curX;
    logic [9:0]  curY;
    logic        coord_valid;
    logic        out_of_range;

    typedef struct {
        int     addr;
        int     x;
        int     y;
        int     oor;
        longint due;
    } exp_t;

    exp_t   sbQ[$];
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;

    addr_to_cart dut (
        .clock        (clock),
        .resetn       (resetn),
        .addr_valid   (addr_valid),
        .curAddress   (curAddress),
        .curX         (curX),
        .curY         (curY),
        .coord_valid  (coord_valid),
        .out_of_range (out_of_range)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: row-major raster arithmetic straight from the address.
    task automatic applyStimulus(input bit v, input int addr);
        exp_t e;
        @(negedge clock);
        addr_valid = v;
        curAddress = 19'(addr);
        if (v) begin
            e.addr = addr;
            e.x    = addr % 640;
            e.y    = addr / 640;
            e.oor  = (addr >= 640 * 480) ? 1 : 0;
            e.due  = cyc + 2;
            sbQ.push_back(e);
        end
    endtask

    // Monitor: every cycle either the oldest expected entry is due now, or the output must be idle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            if (sbQ.size() > 0 && sbQ[0].due == cyc) begin
                e = sbQ.pop_front();
                checkOutput($sformatf("coord_valid@addr%0d", e.addr), int'(coord_valid), 1);
                checkOutput($sformatf("curX@addr%0d", e.addr), int'(curX), e.x);
                checkOutput($sformatf("curY@addr%0d", e.addr), int'(curY), e.y);
                checkOutput($sformatf("out_of_range@addr%0d", e.addr), int'(out_of_range), e.oor);
            end else begin
                checkOutput($sformatf("coord_valid_idle@cyc%0d", cyc), int'(coord_valid), 0);
            end
        end
    end

    initial begin
        int edgeAddrs[8];
        int drain;
        edgeAddrs = '{0, 639, 640, 25940, 307199, 307200, 524287, 523647};

        resetn     = 1'b0;
        addr_valid = 1'b0;
        curAddress = '0;
        #2;
        checkOutput("reset_curX", int'(curX), 0);
        checkOutput("reset_curY", int'(curY), 0);
        checkOutput("reset_coord_valid", int'(coord_valid), 0);
        checkOutput("reset_out_of_range", int'(out_of_range), 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, edgeAddrs[i]);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, int'($urandom_range(0, 524287)));

        for (int i = 0; i < 20000; i++) begin
            if (i % 97 == 0)
                applyStimulus(1'b1, edgeAddrs[$urandom_range(0, 7)]);
            else
                applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 524287)));
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0);

        // Two valid entries in flight, then an asynchronous reset between clock edges.
        applyStimulus(1'b1, 1000);
        applyStimulus(1'b1, 2000);
        @(posedge clock);
        #2;
        resetn     = 1'b0;
        addr_valid = 1'b0;
        sbQ.delete();
        #1;
        checkOutput("midreset_curX", int'(curX), 0);
        checkOutput("midreset_curY", int'(curY), 0);
        checkOutput("midreset_coord_valid", int'(coord_valid), 0);
        checkOutput("midreset_out_of_range", int'(out_of_range), 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        applyStimulus(1'b1, 1280);
        applyStimulus(1'b1, 307200);

        drain = 0;
        while (sbQ.size() > 0 && drain < 20) begin
            applyStimulus(1'b0, 0);
            drain++;
        end
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sbQ.size());
        end
        repeat (3) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
